mpl_axi_lite_regs: RTL and testbench
====================================

// Module: mpl_axi_lite_regs
// PURPOSE
// AXI4-Lite slave register file for the MPL accelerator; it is the S00_AXI endpoint the lite master BFM drives.
// Holds four R/W registers (ctrl, opA, opB, aux) and two RO registers (status, result).
// Converts a ctrl write into a one-cycle start pulse to the MPL core and tracks busy/done.
// Latches the core's result for readback.
// PARAMETERS
// C_S_AXI_DATA_WIDTH  32  data bus width; only 32 is supported.
// C_S_AXI_ADDR_WIDTH  5   byte address width; offsets 0x00-0x14 are decoded using addr[4:2].
// PORTS
// S_AXI_ACLK     in   1   single clock
// S_AXI_ARESETN  in   1   synchronous, active-low reset
// S_AXI_AWADDR   in   5   write address
// S_AXI_AWPROT   in   3   ignored
// S_AXI_AWVALID  in   1   write address valid
// S_AXI_AWREADY  out  1   write address ready
// S_AXI_WDATA    in   32  write data
// S_AXI_WSTRB    in   4   byte enables
// S_AXI_WVALID   in   1   write data valid
// S_AXI_WREADY   out  1   write data ready
// S_AXI_BRESP    out  2   write response; always 2'b00 (OKAY)
// S_AXI_BVALID   out  1   write response valid
// S_AXI_BREADY   in   1   write response ready
// S_AXI_ARADDR   in   5   read address
// S_AXI_ARPROT   in   3   ignored
// S_AXI_ARVALID  in   1   read address valid
// S_AXI_ARREADY  out  1   read address ready
// S_AXI_RDATA    out  32  read data
// S_AXI_RRESP    out  2   read response; always 2'b00
// S_AXI_RVALID   out  1   read data valid
// S_AXI_RREADY   in   1   read data ready
// core_op_a      out  32  register 1 contents
// core_op_b      out  32  register 2 contents
// core_start     out  1   one-cycle start pulse to the MPL core
// core_done      in   1   one-cycle completion pulse from the core
// core_result    in   32  result; valid while core_done=1
// BEHAVIOUR
// Reset: all outputs 0, all registers 0, busy=0, done=0. Reset taken mid-transaction aborts it; no B/R response is issued.
// Write path:
//  - The slave samples AWVALID&&WVALID=1 with BVALID=0 and AWREADY=0.
//  - Next cycle it asserts AWREADY=WREADY=1 for exactly one cycle, and the register write occurs on that edge.
//  - BVALID rises the following cycle and holds until BREADY; write-to-BVALID latency is 2 cycles.
//  - The slave never accepts AW without W (or the reverse); a lone valid waits.
//  - No new write is accepted while BVALID=1.
// Read path:
//  - The slave samples ARVALID=1 with RVALID=0 and ARREADY=0, then pulses ARREADY for one cycle.
//  - RDATA and RVALID register on that edge and hold (RDATA stable) until RREADY.
// Map (addr[4:2]):
//  - 0 ctrl: R/W.
//  - 1 opA: R/W.
//  - 2 opB: R/W.
//  - 3 aux: R/W.
//  - 4 status: RO, {30'b0, done, busy}.
//  - 5 result: RO.
//  - 6,7: read 0.
//  - Writes to 4-7 are ignored but still return OKAY.
// WSTRB[i] gates byte i; untouched bytes keep their value. All R/W registers read back exactly what was written.
// Start/busy/done:
//  - A write to ctrl with byte0 strobed, WDATA[0]=1 and busy=0 makes core_start=1 on the cycle after the write edge. It sets busy=1 and clears done.
//  - A start write while busy=1 updates ctrl but produces no pulse.
//  - core_done while busy: busy<=0, done<=1, result<=core_result.
//  - core_done while idle is ignored.
//  - If core_done and a start write land on the same edge: done/result capture first, then the start is evaluated against busy=0 and is honoured.
// done is sticky; it is cleared only by the next accepted start or by reset.
// Reads and writes are independent and may complete in the same cycle.
// TESTING
// 1. Write 0x0101FFFF/0xabcd0001/0xdead0011/0xbeef0011 to 0x00/04/08/0C -> each BRESP=OKAY; readback equal. Exactly one core_start (ctrl bit0=1).
// 2. Write 0x12345678 to 0x04, then WSTRB=4'b0010 with WDATA=0xAAAAAAAA -> read 0x04 returns 0x1234AA78.
// 3. AWVALID raised 3 cycles before WVALID -> no AWREADY until both valid; one register update; one BVALID.
// 4. Start, core_done with result=0xCAFEF00D after 10 cycles -> status=0x1 during the run, then 0x2; result reads 0xCAFEF00D.
// 5. Hold BREADY/RREADY low 5 cycles -> BVALID/RVALID/RDATA stable; a second AW/W is not accepted until B completes.
// 6. Assert S_AXI_ARESETN=0 while BVALID=1 and busy=1 -> the next cycle shows all outputs 0 and all registers 0.

Source files
------------

// File: rtl/mpl_axi_lite_regs.sv
// AXI4-Lite register file for the MPL core: ctrl/opA/opB/aux R/W, status/result RO, core start/busy/done tracking.
// Latency: AW+W sampled -> AWREADY/WREADY next cycle (write lands) -> BVALID next; AR -> ARREADY -> RVALID.
// Backpressure: BVALID/RVALID/RDATA hold until BREADY/RREADY; no new write/read is taken while its response is pending.
module mpl_axi_lite_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   core_op_a,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   core_op_b,
  output logic                            core_start,
  input  logic                            core_done,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   core_result
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ACK = 2'd1, W_RESP = 2'd2} wr_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ACK = 2'd1, R_DATA = 2'd2} rd_state_t;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic [DW-1:0] ctrl_q, opa_q, opb_q, aux_q, result_q, rdata_q, rd_mux;
  logic          busy_q, done_q, start_q;
  logic [2:0]    wr_sel, rd_sel;
  logic          wr_en, start_req, start_go;
  logic          unused_ok;

  function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_v,
                                               input logic [DW-1:0] new_v,
                                               input logic [SW-1:0] strb);
    logic [DW-1:0] r;
    r = old_v;
    for (int i = 0; i < SW; i++)
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  // Write channel
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) wr_state <= W_IDLE;
    else                wr_state <= wr_next;
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE:  if (S_AXI_AWVALID && S_AXI_WVALID) wr_next = W_ACK;
      W_ACK:   wr_next = W_RESP;
      W_RESP:  if (S_AXI_BREADY) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  always_comb begin
    S_AXI_AWREADY = (wr_state == W_ACK);
    S_AXI_WREADY  = (wr_state == W_ACK);
    S_AXI_BVALID  = (wr_state == W_RESP);
    S_AXI_BRESP   = 2'b00;
  end

  // Read channel
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) rd_state <= R_IDLE;
    else                rd_state <= rd_next;
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:  if (S_AXI_ARVALID) rd_next = R_ACK;
      R_ACK:   rd_next = R_DATA;
      R_DATA:  if (S_AXI_RREADY) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  always_comb begin
    S_AXI_ARREADY = (rd_state == R_ACK);
    S_AXI_RVALID  = (rd_state == R_DATA);
    S_AXI_RDATA   = rdata_q;
    S_AXI_RRESP   = 2'b00;
  end

  assign wr_sel    = S_AXI_AWADDR[4:2];
  assign rd_sel    = S_AXI_ARADDR[4:2];
  assign wr_en     = (wr_state == W_ACK);
  assign start_req = wr_en && (wr_sel == 3'd0) && S_AXI_WSTRB[0] && S_AXI_WDATA[0];
  // A done landing on the same edge frees the core first, so the start is honoured.
  assign start_go  = start_req && !(busy_q && !core_done);
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  always_comb begin
    rd_mux = '0;
    case (rd_sel)
      3'd0:    rd_mux = ctrl_q;
      3'd1:    rd_mux = opa_q;
      3'd2:    rd_mux = opb_q;
      3'd3:    rd_mux = aux_q;
      3'd4:    rd_mux = {{(DW-2){1'b0}}, done_q, busy_q};
      3'd5:    rd_mux = result_q;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      ctrl_q   <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      aux_q    <= '0;
      result_q <= '0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      start_q <= start_go;
      if (wr_en) begin
        case (wr_sel)
          3'd0:    ctrl_q <= apply_strb(ctrl_q, S_AXI_WDATA, S_AXI_WSTRB);
          3'd1:    opa_q  <= apply_strb(opa_q,  S_AXI_WDATA, S_AXI_WSTRB);
          3'd2:    opb_q  <= apply_strb(opb_q,  S_AXI_WDATA, S_AXI_WSTRB);
          3'd3:    aux_q  <= apply_strb(aux_q,  S_AXI_WDATA, S_AXI_WSTRB);
          default: ;
        endcase
      end
      if (core_done && busy_q) begin
        busy_q   <= 1'b0;
        done_q   <= 1'b1;
        result_q <= core_result;
      end
      if (start_go) begin
        busy_q <= 1'b1;
        done_q <= 1'b0;
      end
      if (rd_state == R_ACK) rdata_q <= rd_mux;
    end
  end

  assign core_op_a  = opa_q;
  assign core_op_b  = opb_q;
  assign core_start = start_q;

endmodule

// File: tb/tb_mpl_axi_lite_regs.sv
// Randomized + directed bench for mpl_axi_lite_regs against a register-map reference model.
module tb_mpl_axi_lite_regs;

  logic tb_ACLK = 1'b0;
  always #5 tb_ACLK = ~tb_ACLK;

  logic        aresetn = 1'b0;
  logic [4:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0, core_result = '0;
  logic [3:0]  wstrb = '0;
  logic        core_done = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid, core_start;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, core_op_a, core_op_b;

  mpl_axi_lite_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) dut (
    .S_AXI_ACLK(tb_ACLK), .S_AXI_ARESETN(aresetn),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .core_op_a(core_op_a), .core_op_b(core_op_b), .core_start(core_start),
    .core_done(core_done), .core_result(core_result)
  );

  int total = 0;
  int bad = 0;
  int start_cnt = 0;

  // Reference model of the programmer-visible state.
  logic [31:0] m_regs [4];
  logic        m_busy, m_done;
  logic [31:0] m_res;
  int          m_starts = 0;

  always @(negedge tb_ACLK) if (core_start) start_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a[4:2])
      3'd0, 3'd1, 3'd2, 3'd3: return m_regs[int'(a[4:2])];
      3'd4:    return {30'b0, m_done, m_busy};
      3'd5:    return m_res;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    m_busy = 1'b0;
    m_done = 1'b0;
    m_res  = '0;
  endtask

  // Called at a negedge; returns at a negedge with the write fully retired.
  task automatic axi_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int lead, input int bhold, input bit dp, input logic [31:0] dres,
                        input bit ovl);
    int n;
    bit exp_start;
    awaddr = a; wdata = d; wstrb = s; awprot = 3'($urandom_range(0, 7));
    awvalid = 1'b1; wvalid = (lead == 0); bready = 1'b0;
    for (int i = 0; i < lead; i++) begin
      @(negedge tb_ACLK);
      chk("aw_alone_wait", 32'(awready), 32'd0);
    end
    wvalid = 1'b1;
    n = 0;
    do begin @(negedge tb_ACLK); n++; end while (!awready && n < 20);
    chk("aw_latency", 32'(n), 32'd1);
    chk("wready_with_aw", 32'(wready), 32'd1);
    chk("bvalid_early", 32'(bvalid), 32'd0);
    awvalid = 1'b0; wvalid = 1'b0;
    if (dp) begin core_done = 1'b1; core_result = dres; end
    if (dp && m_busy) begin m_busy = 1'b0; m_done = 1'b1; m_res = dres; end
    if (a[4:2] < 3'd4) m_regs[int'(a[4:2])] = merge(m_regs[int'(a[4:2])], d, s);
    exp_start = (a[4:2] == 3'd0) && s[0] && d[0] && !m_busy;
    if (exp_start) begin m_busy = 1'b1; m_done = 1'b0; m_starts++; end
    @(negedge tb_ACLK);
    core_done = 1'b0;
    chk("bvalid", 32'(bvalid), 32'd1);
    chk("bresp", 32'(bresp), 32'd0);
    chk("core_start", 32'(core_start), 32'(exp_start));
    if (ovl) begin
      awaddr = 5'h18; wdata = 32'h5A5A5A5A; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    end
    for (int i = 0; i < bhold; i++) begin
      @(negedge tb_ACLK);
      chk("bvalid_hold", 32'(bvalid), 32'd1);
      if (ovl) chk("aw_blocked_by_b", 32'(awready), 32'd0);
    end
    bready = 1'b1;
    @(negedge tb_ACLK);
    bready = 1'b0;
    chk("bvalid_clear", 32'(bvalid), 32'd0);
  endtask

  task automatic axi_rd(input logic [4:0] a, input int rhold, output logic [31:0] v);
    int n;
    logic [31:0] exp;
    araddr = a; arprot = 3'($urandom_range(0, 7)); arvalid = 1'b1; rready = 1'b0;
    n = 0;
    do begin @(negedge tb_ACLK); n++; end while (!arready && n < 20);
    chk("ar_latency", 32'(n), 32'd1);
    arvalid = 1'b0;
    exp = m_read(a);
    @(negedge tb_ACLK);
    chk("rvalid", 32'(rvalid), 32'd1);
    chk("rresp", 32'(rresp), 32'd0);
    chk("rdata", rdata, exp);
    v = rdata;
    for (int i = 0; i < rhold; i++) begin
      @(negedge tb_ACLK);
      chk("rvalid_hold", 32'(rvalid), 32'd1);
      chk("rdata_hold", rdata, exp);
    end
    rready = 1'b1;
    @(negedge tb_ACLK);
    rready = 1'b0;
    chk("rvalid_clear", 32'(rvalid), 32'd0);
  endtask

  task automatic done_pulse(input logic [31:0] r);
    core_done = 1'b1; core_result = r;
    @(negedge tb_ACLK);
    core_done = 1'b0;
    if (m_busy) begin m_busy = 1'b0; m_done = 1'b1; m_res = r; end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_awready"}, 32'(awready), 32'd0);
    chk({tag, "_wready"},  32'(wready),  32'd0);
    chk({tag, "_bvalid"},  32'(bvalid),  32'd0);
    chk({tag, "_arready"}, 32'(arready), 32'd0);
    chk({tag, "_rvalid"},  32'(rvalid),  32'd0);
    chk({tag, "_rdata"},   rdata,        32'd0);
    chk({tag, "_op_a"},    core_op_a,    32'd0);
    chk({tag, "_op_b"},    core_op_b,    32'd0);
    chk({tag, "_start"},   32'(core_start), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] v;
    int op;
    m_reset();
    repeat (3) @(negedge tb_ACLK);
    chk_all_zero("reset");
    aresetn = 1'b1;
    @(negedge tb_ACLK);

    // Basic R/W of the four writable registers; only ctrl bit0 starts the core.
    axi_wr(5'h00, 32'h0101FFFF, 4'hF, 0, 0, 1'b0, '0, 1'b0);
    axi_wr(5'h04, 32'hABCD0001, 4'hF, 0, 0, 1'b0, '0, 1'b0);
    axi_wr(5'h08, 32'hDEAD0011, 4'hF, 0, 0, 1'b0, '0, 1'b0);
    axi_wr(5'h0C, 32'hBEEF0011, 4'hF, 0, 0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) axi_rd(5'(i * 4), 0, v);
    axi_rd(5'h04, 0, v);
    chk("t1_opa_literal", v, 32'hABCD0001);
    chk("t1_start_count", 32'(start_cnt), 32'd1);
    chk("t1_op_b", core_op_b, 32'hDEAD0011);

    // Byte strobes.
    axi_wr(5'h04, 32'h12345678, 4'hF, 0, 0, 1'b0, '0, 1'b0);
    axi_wr(5'h04, 32'hAAAAAAAA, 4'b0010, 0, 0, 1'b0, '0, 1'b0);
    axi_rd(5'h04, 0, v);
    chk("t2_strb_literal", v, 32'h1234AA78);

    // AW arrives 3 cycles ahead of W.
    axi_wr(5'h0C, 32'h0F0F1234, 4'hF, 3, 0, 1'b0, '0, 1'b0);
    axi_rd(5'h0C, 0, v);

    // Start / busy / done, sticky done, idle done ignored, same-edge done+start.
    done_pulse(32'h11112222);
    axi_wr(5'h00, 32'h00000001, 4'hF, 0, 0, 1'b0, '0, 1'b0);
    axi_rd(5'h10, 0, v);
    chk("t4_status_busy", v, 32'h1);
    axi_wr(5'h00, 32'h00000003, 4'hF, 0, 0, 1'b0, '0, 1'b0);
    axi_rd(5'h00, 0, v);
    done_pulse(32'hCAFEF00D);
    axi_rd(5'h10, 0, v);
    chk("t4_status_done", v, 32'h2);
    axi_rd(5'h14, 0, v);
    chk("t4_result", v, 32'hCAFEF00D);
    done_pulse(32'hDEADBEEF);
    axi_rd(5'h14, 0, v);
    axi_rd(5'h10, 0, v);
    axi_wr(5'h00, 32'h00000001, 4'hF, 0, 0, 1'b0, '0, 1'b0);
    axi_wr(5'h00, 32'h00000001, 4'hF, 0, 0, 1'b1, 32'h0BADF00D, 1'b0);
    axi_rd(5'h10, 0, v);
    chk("t4_same_edge_status", v, 32'h1);
    axi_rd(5'h14, 0, v);

    // Response backpressure; a queued write waits for B.
    axi_wr(5'h0C, 32'h5555AAAA, 4'hF, 0, 5, 1'b0, '0, 1'b1);
    axi_wr(5'h18, 32'h5A5A5A5A, 4'hF, 0, 0, 1'b0, '0, 1'b0);
    axi_rd(5'h0C, 5, v);
    axi_rd(5'h18, 0, v);

    // Randomized mix.
    for (int it = 0; it < 150; it++) begin
      op = $urandom_range(0, 4);
      if (op <= 1)
        axi_wr(5'($urandom_range(0, 7) << 2), $urandom, 4'($urandom_range(0, 15)),
               $urandom_range(0, 2), $urandom_range(0, 2),
               1'($urandom_range(0, 3) == 0), $urandom, 1'b0);
      else if (op <= 3)
        axi_rd(5'($urandom_range(0, 7) << 2), $urandom_range(0, 2), v);
      else
        done_pulse($urandom);
      chk("rand_op_a", core_op_a, m_regs[1]);
      chk("rand_op_b", core_op_b, m_regs[2]);
    end
    chk("rand_start_count", 32'(start_cnt), 32'(m_starts));

    // Reset while a write response is pending and the core is busy.
    if (!m_busy) axi_wr(5'h00, 32'h00000001, 4'hF, 0, 0, 1'b0, '0, 1'b0);
    axi_rd(5'h10, 0, v);
    awaddr = 5'h04; wdata = 32'hFFFFFFFF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    for (int n = 0; n < 20 && !awready; n++) @(negedge tb_ACLK);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge tb_ACLK);
    chk("t6_bvalid_before_reset", 32'(bvalid), 32'd1);
    aresetn = 1'b0;
    @(negedge tb_ACLK);
    chk_all_zero("t6");
    m_reset();
    aresetn = 1'b1;
    @(negedge tb_ACLK);
    for (int i = 0; i < 6; i++) axi_rd(5'(i * 4), 0, v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
